taillight_cmd_encoder: RTL and testbench

Front end of the taillight datapath. It conditions the four raw driver switches: left, right, brake and hazard. It arbitrates them through a small state machine and drives the registered 4-bit command code consumed by the taillight LED sequencer. It runs on the same slow clock as the sequencer, with one code update per clock at most.

---
 rtl/taillight_cmd_encoder.sv | 240 ++++++++++++++++++++++++
 tb/tb_taillight_cmd_encoder.sv | 301 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/taillight_cmd_encoder.sv
// taillight_cmd_encoder
//
// Front end of the taillight datapath. The four raw driver switches are synchronized,
// debounced and arbitrated by a small FSM. The result is a registered 4-bit command code
// {hazard, brake, left_n_right, turn} for the LED sequencer.
//
// Build option: define TURN_AUTOCANCEL_EN for latched turn signals with auto-cancel.
// Without it, turn signals follow the debounced switch levels, no cancel counter is built
// and cancel_pulse_o is tied low.
//
// Parameters:
//   DEBOUNCE_CYCLES  consecutive disagreeing cycles before a debounced level flips (1..255)
//   CANCEL_CYCLES    turn auto-cancel duration in cycles (1..65535, latched build only)
//
// Ports:
//   clk             clock
//   rst             asynchronous active-low reset
//   sw_left_i       raw left-turn switch (asynchronous, active-high)
//   sw_right_i      raw right-turn switch (asynchronous, active-high)
//   sw_brake_i      raw brake switch (asynchronous, active-high)
//   sw_hazard_i     raw hazard switch (asynchronous, active-high)
//   state_o         registered command code {hazard, brake, left_n_right, turn}
//   cancel_pulse_o  one-cycle pulse, coincident with the IDLE code after an auto-cancel
module taillight_cmd_encoder #(
    parameter int unsigned DEBOUNCE_CYCLES = 4,
    parameter int unsigned CANCEL_CYCLES   = 24
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       sw_left_i,
    input  logic       sw_right_i,
    input  logic       sw_brake_i,
    input  logic       sw_hazard_i,
    output logic [3:0] state_o,
    output logic       cancel_pulse_o
);

    localparam int unsigned NumSw     = 4;
    localparam int unsigned IdxLeft   = 0;
    localparam int unsigned IdxRight  = 1;
    localparam int unsigned IdxBrake  = 2;
    localparam int unsigned IdxHazard = 3;

    localparam logic [7:0]  DbLast     = 8'(DEBOUNCE_CYCLES - 1);
    localparam logic [15:0] CancelLoad = 16'(CANCEL_CYCLES - 1);

    typedef enum logic [1:0] {StIdle, StLeft, StRight, StHazard} fsm_e;

    // ------------------------------------------------------------------
    // Synchronizers
    // ------------------------------------------------------------------
    logic [NumSw-1:0] sw_raw;
    logic [NumSw-1:0] sync1_q, sync2_q;

    assign sw_raw = {sw_hazard_i, sw_brake_i, sw_right_i, sw_left_i};

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= sw_raw;
            sync2_q <= sync1_q;
        end
    end

    // ------------------------------------------------------------------
    // Debouncers
    // ------------------------------------------------------------------
    logic [NumSw-1:0]      level_q, level_d;
    logic [NumSw-1:0][7:0] db_cnt_q, db_cnt_d;

    always_comb begin
        level_d  = level_q;
        db_cnt_d = '0;
        for (int i = 0; i < NumSw; i++) begin
            if (sync2_q[i] != level_q[i]) begin
                // The D-th consecutive disagreeing cycle flips the level; counter clears.
                if (db_cnt_q[i] == DbLast) begin
                    level_d[i] = ~level_q[i];
                end else begin
                    db_cnt_d[i] = db_cnt_q[i] + 8'd1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            level_q  <= '0;
            db_cnt_q <= '0;
        end else begin
            level_q  <= level_d;
            db_cnt_q <= db_cnt_d;
        end
    end

    logic lvl_left, lvl_right, lvl_brake, lvl_hazard;

    assign lvl_left   = level_q[IdxLeft];
    assign lvl_right  = level_q[IdxRight];
    assign lvl_brake  = level_q[IdxBrake];
    assign lvl_hazard = level_q[IdxHazard];

    // ------------------------------------------------------------------
    // Arbitration FSM
    // ------------------------------------------------------------------
    fsm_e       fsm_q, fsm_d;
    logic [3:0] state_q, state_d;

`ifdef TURN_AUTOCANCEL_EN
    logic [1:0]  prev_q;
    logic        rise_left, rise_right;
    logic [15:0] cnt_q, cnt_d;
    logic        pulse_q, pulse_d;

    assign rise_left  = lvl_left & ~prev_q[0];
    assign rise_right = lvl_right & ~prev_q[1];

    always_comb begin
        fsm_d   = fsm_q;
        cnt_d   = cnt_q;
        pulse_d = 1'b0;
        if (lvl_hazard) begin
            fsm_d = StHazard;
            cnt_d = '0;
        end else begin
            unique case (fsm_q)
                StHazard: fsm_d = StIdle;
                StIdle: begin
                    // Simultaneous rises are ambiguous; stay idle.
                    if (rise_left && !rise_right) begin
                        fsm_d = StLeft;
                        cnt_d = CancelLoad;
                    end else if (rise_right && !rise_left) begin
                        fsm_d = StRight;
                        cnt_d = CancelLoad;
                    end
                end
                StLeft: begin
                    // A same-direction re-press wins over an expiry in the same cycle.
                    if (rise_left) begin
                        cnt_d = CancelLoad;
                    end else if (rise_right) begin
                        fsm_d = StRight;
                        cnt_d = CancelLoad;
                    end else if (cnt_q == '0) begin
                        fsm_d   = StIdle;
                        pulse_d = 1'b1;
                    end else begin
                        cnt_d = cnt_q - 16'd1;
                    end
                end
                StRight: begin
                    if (rise_right) begin
                        cnt_d = CancelLoad;
                    end else if (rise_left) begin
                        fsm_d = StLeft;
                        cnt_d = CancelLoad;
                    end else if (cnt_q == '0) begin
                        fsm_d   = StIdle;
                        pulse_d = 1'b1;
                    end else begin
                        cnt_d = cnt_q - 16'd1;
                    end
                end
                default: fsm_d = StIdle;
            endcase
        end
    end

    assign cancel_pulse_o = pulse_q;
`else
    // Set by hazard; a turn switch held through a hazard must be released before it can
    // light the turn signal again.
    logic blk_q, blk_d;

    always_comb begin
        blk_d = blk_q;
        if (lvl_hazard) begin
            blk_d = 1'b1;
        end else if (!lvl_left && !lvl_right) begin
            blk_d = 1'b0;
        end

        fsm_d = StIdle;
        if (lvl_hazard) begin
            fsm_d = StHazard;
        end else if (fsm_q == StHazard) begin
            fsm_d = StIdle;
        end else if (lvl_left && !lvl_right && !blk_q) begin
            fsm_d = StLeft;
        end else if (lvl_right && !lvl_left && !blk_q) begin
            fsm_d = StRight;
        end
    end

    logic unused_cancel;
    assign unused_cancel  = ^CancelLoad;
    assign cancel_pulse_o = 1'b0;
`endif

    // Output code is decoded from the next state so it registers alongside it.
    always_comb begin
        state_d = {1'b0, lvl_brake, 2'b00};
        unique case (fsm_d)
            StHazard: state_d = {1'b1, lvl_brake, 2'b00};
            StLeft:   state_d = {1'b0, lvl_brake, 2'b11};
            StRight:  state_d = {1'b0, lvl_brake, 2'b01};
            default:  state_d = {1'b0, lvl_brake, 2'b00};
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fsm_q   <= StIdle;
            state_q <= 4'b0000;
`ifdef TURN_AUTOCANCEL_EN
            prev_q  <= '0;
            cnt_q   <= '0;
            pulse_q <= 1'b0;
`else
            blk_q   <= 1'b0;
`endif
        end else begin
            fsm_q   <= fsm_d;
            state_q <= state_d;
`ifdef TURN_AUTOCANCEL_EN
            prev_q  <= {lvl_right, lvl_left};
            cnt_q   <= cnt_d;
            pulse_q <= pulse_d;
`else
            blk_q   <= blk_d;
`endif
        end
    end

    assign state_o = state_q;

endmodule

// File: tb/tb_taillight_cmd_encoder.sv
// Testbench for taillight_cmd_encoder. Works for both builds (TURN_AUTOCANCEL_EN defined
// or not): a scenario table, hand-written corner sequences and randomized switch activity
// checked cycle by cycle against a behavioural model.
module tb_taillight_cmd_encoder;

    localparam int unsigned Deb    = 4;
    localparam int unsigned Cancel = 24;

    logic       clk = 1'b0;
    logic       rst;
    logic       sw_left, sw_right, sw_brake, sw_hazard;
    logic [3:0] state;
    logic       cancel_pulse;

    always #5 clk = ~clk;

    taillight_cmd_encoder #(
        .DEBOUNCE_CYCLES(Deb),
        .CANCEL_CYCLES  (Cancel)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .sw_left_i     (sw_left),
        .sw_right_i    (sw_right),
        .sw_brake_i    (sw_brake),
        .sw_hazard_i   (sw_hazard),
        .state_o       (state),
        .cancel_pulse_o(cancel_pulse)
    );

    int n_cmp = 0;
    int n_err = 0;

    function automatic void check(string name, logic [3:0] act, logic [3:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
        end
    endfunction

    // ------------------------------------------------------------------
    // Behavioural model. Switch vectors are {hazard, brake, right, left}.
    // States: 0 idle, 1 left, 2 right, 3 hazard.
    // ------------------------------------------------------------------
    logic [3:0] m_s1, m_s2, m_lvl;
    int         m_run [4];
    logic [1:0] m_prev;
    int         m_st, m_cnt;
    bit         m_blk;
    logic [3:0] m_code;
    logic       m_pulse;

    function automatic void model_reset();
        m_s1 = '0; m_s2 = '0; m_lvl = '0; m_prev = '0;
        for (int i = 0; i < 4; i++) m_run[i] = 0;
        m_st = 0; m_cnt = 0; m_blk = 0; m_code = '0; m_pulse = 1'b0;
    endfunction

    function automatic void model_step(logic [3:0] raw);
        bit         hz, br, l, r, rl, rr, same, opp;
        int         nst;
        logic [3:0] nl;
        hz = m_lvl[3]; br = m_lvl[2]; r = m_lvl[1]; l = m_lvl[0];
        rl = l && !m_prev[0];
        rr = r && !m_prev[1];
        nst = m_st;
        m_pulse = 1'b0;
        if (hz) begin
            nst = 3;
            m_cnt = 0;
        end else if (m_st == 3) begin
            nst = 0;
        end
`ifdef TURN_AUTOCANCEL_EN
        else if (m_st == 0) begin
            if (rl != rr) begin
                nst = rl ? 1 : 2;
                m_cnt = Cancel - 1;
            end
        end else begin
            same = (m_st == 1) ? rl : rr;
            opp  = (m_st == 1) ? rr : rl;
            if (same) m_cnt = Cancel - 1;
            else if (opp) begin
                nst = 3 - m_st;
                m_cnt = Cancel - 1;
            end else if (m_cnt == 0) begin
                nst = 0;
                m_pulse = 1'b1;
            end else m_cnt--;
        end
`else
        else if (l != r && !m_blk) nst = l ? 1 : 2;
        else nst = 0;
        if (hz) m_blk = 1;
        else if (!l && !r) m_blk = 0;
`endif
        m_st = nst;
        m_code = 4'(((nst == 3) ? 8 : 0) + (br ? 4 : 0) + ((nst == 1) ? 2 : 0) +
                    ((nst == 1 || nst == 2) ? 1 : 0));
        // Level flips once the synchronized input has disagreed for Deb cycles in a row.
        nl = m_lvl;
        for (int i = 0; i < 4; i++) begin
            if (m_s2[i] != m_lvl[i]) begin
                m_run[i]++;
                if (m_run[i] >= Deb) begin
                    nl[i] = ~m_lvl[i];
                    m_run[i] = 0;
                end
            end else m_run[i] = 0;
        end
        m_prev = {r, l};
        m_lvl = nl;
        m_s2 = m_s1;
        m_s1 = raw;
    endfunction

    task automatic set_sw(input logic [3:0] v);
        {sw_hazard, sw_brake, sw_right, sw_left} = v;
    endtask

    // One clock: advance the model with the values the DUT sampled, then compare.
    task automatic tick();
        @(posedge clk);
        if (rst) model_step({sw_hazard, sw_brake, sw_right, sw_left});
        #2;
        check("model_state", state, m_code);
        check("model_pulse", {3'b000, cancel_pulse}, {3'b000, m_pulse});
    endtask

    task automatic async_reset();
        #1;
        rst = 1'b0;
        #1;
        model_reset();
        check("async_rst_state", state, 4'b0000);
        check("async_rst_pulse", {3'b000, cancel_pulse}, 4'b0000);
        @(negedge clk);
        rst = 1'b1;
    endtask

    typedef struct {
        logic [3:0] sw;
        int         cyc;
        logic [3:0] exp;
    } vec_t;

    vec_t vecs[$];

    initial begin
        int run;
        bit seen;
`ifdef TURN_AUTOCANCEL_EN
        vecs.push_back('{4'b0001, 10, 4'b0011});
        vecs.push_back('{4'b0000, 10, 4'b0011}); // release keeps the turn
        vecs.push_back('{4'b0010, 10, 4'b0001}); // opposite press switches
        vecs.push_back('{4'b0000, 30, 4'b0000}); // expired
        vecs.push_back('{4'b0011, 10, 4'b0000}); // simultaneous rises ignored
        vecs.push_back('{4'b0000, 10, 4'b0000});
        vecs.push_back('{4'b1001, 10, 4'b1000});
        vecs.push_back('{4'b0001, 10, 4'b0000}); // held through hazard: no rise
        vecs.push_back('{4'b0100, 10, 4'b0100});
        vecs.push_back('{4'b0110, 10, 4'b0101});
        vecs.push_back('{4'b1110, 10, 4'b1100});
        vecs.push_back('{4'b0000, 10, 4'b0000});
`else
        vecs.push_back('{4'b0001, 10, 4'b0011});
        vecs.push_back('{4'b0101, 10, 4'b0111});
        vecs.push_back('{4'b0010, 10, 4'b0001});
        vecs.push_back('{4'b0011, 10, 4'b0000}); // both turns
        vecs.push_back('{4'b0001, 10, 4'b0011});
        vecs.push_back('{4'b1010, 10, 4'b1000});
        vecs.push_back('{4'b0010, 10, 4'b0000}); // held through hazard: no resume
        vecs.push_back('{4'b0000, 10, 4'b0000});
        vecs.push_back('{4'b0010, 10, 4'b0001});
        vecs.push_back('{4'b0100, 10, 4'b0100});
        vecs.push_back('{4'b0110, 10, 4'b0101}); // brake plus right
        vecs.push_back('{4'b1110, 10, 4'b1100});
        vecs.push_back('{4'b0110, 10, 4'b0100});
        vecs.push_back('{4'b0000, 10, 4'b0000});
`endif

        // Reset with every switch held.
        rst = 1'b0;
        set_sw(4'b1111);
        model_reset();
        #3;
        check("rst_state", state, 4'b0000);
        check("rst_pulse", {3'b000, cancel_pulse}, 4'b0000);
        tick();
        tick();
        @(negedge clk);
        rst = 1'b1;
        for (int k = 0; k < 8; k++) begin
            tick();
            if (k == 5) check("rst_release_edge5", state, 4'b0000);
            if (k == 6) check("rst_release_edge6", state, 4'b1100);
        end
        set_sw(4'b0000);
        repeat (12) tick();

        foreach (vecs[i]) begin
            set_sw(vecs[i].sw);
            repeat (vecs[i].cyc) tick();
            check($sformatf("vec%0d", i), state, vecs[i].exp);
        end

`ifndef TURN_AUTOCANCEL_EN
        // Glitch: a 3-cycle pulse is filtered, a 10-cycle pulse passes.
        set_sw(4'b0001);
        repeat (3) tick();
        set_sw(4'b0000);
        for (int k = 0; k < 12; k++) begin
            tick();
            check("glitch3", state, 4'b0000);
        end
        set_sw(4'b0001);
        for (int k = 0; k < 20; k++) begin
            if (k == 10) set_sw(4'b0000);
            tick();
            if (k == 5) check("glitch10_edge5", state, 4'b0000);
            if (k == 6) check("glitch10_edge6", state, 4'b0011);
            if (k == 15) check("glitch10_edge15", state, 4'b0011);
            if (k == 16) check("glitch10_edge16", state, 4'b0000);
        end
`else
        // Auto-cancel: a 6-cycle left press holds the turn for exactly Cancel cycles.
        set_sw(4'b0001);
        for (int k = 0; k < 7; k++) begin
            if (k == 6) set_sw(4'b0000);
            tick();
            if (k == 6) check("cancel_entry_edge6", state, 4'b0011);
        end
        run = 1;
        seen = 0;
        for (int k = 0; k < 60 && !seen; k++) begin
            tick();
            if (state == 4'b0011) run++;
            else begin
                seen = 1;
                check("cancel_idle_code", state, 4'b0000);
                check("cancel_pulse_hi", {3'b000, cancel_pulse}, 4'b0001);
            end
        end
        check("cancel_len", 4'(run == Cancel), 4'd1);
        tick();
        check("cancel_pulse_lo", {3'b000, cancel_pulse}, 4'b0000);

        // Right press mid-turn switches direction and restarts the count.
        set_sw(4'b0001);
        repeat (6) tick();
        set_sw(4'b0000);
        repeat (10) tick();
        check("mid_turn_left", state, 4'b0011);
        set_sw(4'b0010);
        seen = 0;
        for (int k = 0; k < 20 && !seen; k++) begin
            tick();
            if (state == 4'b0001) seen = 1;
        end
        check("mid_turn_right_seen", {3'b000, seen}, 4'b0001);
        set_sw(4'b0000);
        run = 1;
        seen = 0;
        for (int k = 0; k < 60 && !seen; k++) begin
            tick();
            if (state == 4'b0001) run++;
            else seen = 1;
        end
        check("mid_turn_restart_len", 4'(run == Cancel), 4'd1);
`endif

        // Asynchronous reset in the middle of a turn, switch still held afterwards.
        set_sw(4'b0001);
        repeat (10) tick();
        check("pre_async_turn", state, 4'b0011);
        async_reset();
        for (int k = 0; k < 10; k++) begin
            tick();
            if (k == 5) check("post_async_edge5", state, 4'b0000);
        end
        check("post_async_redebounced", state, 4'b0011);
        set_sw(4'b0000);
        repeat (12) tick();

        // Randomized switch activity with occasional asynchronous resets.
        for (int seg = 0; seg < 300; seg++) begin
            logic [3:0] v;
            v = 4'($urandom_range(0, 7));
            v[3] = ($urandom_range(0, 7) == 0);
            set_sw(v);
            if ($urandom_range(0, 59) == 0) async_reset();
            repeat ($urandom_range(1, 12)) tick();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
